// File: rtl/reg_file.sv
// Writeback-path register file: captures the destination in the writeback phase,
// commits dr2_out one edge later, and serves two registered operands in decode.
module reg_file #(
   parameter int unsigned AW   = 5,
   parameter int unsigned DW   = 32,
   parameter int unsigned PHW  = 4,
   parameter int unsigned PH_D = 1,
   parameter int unsigned PH_W = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [PHW-1:0] phase,
   input  logic           wr_en,
   input  logic [AW-1:0]  wr_addr,
   input  logic [DW-1:0]  wr_data,
   input  logic [AW-1:0]  rs_addr,
   input  logic [AW-1:0]  rt_addr,
   output logic [DW-1:0]  rs_out,
   output logic [DW-1:0]  rt_out,
   output logic           wb_busy
);

   localparam int unsigned NREG = 1 << AW;

   logic [DW-1:0] regs [NREG];
   logic          wb_pend;
   logic [AW-1:0] wb_addr_q;
   logic [DW-1:0] rs_sel_c;
   logic [DW-1:0] rt_sel_c;

   // Operand select: index 0 is zero, a committing write is forwarded.
   function automatic logic [DW-1:0] sel(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      if (a == '0)
         v = '0;
      else if (wb_pend && (a == wb_addr_q))
         v = wr_data;
      else
         v = regs[a];
      return v;
   endfunction

   always_comb begin
      rs_sel_c = sel(rs_addr);
      rt_sel_c = sel(rt_addr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREG); i++)
            regs[i] <= '0;
         wb_pend   <= 1'b0;
         wb_addr_q <= '0;
         rs_out    <= '0;
         rt_out    <= '0;
      end else begin
         if (phase[PH_W]) begin
            wb_pend   <= wr_en && (wr_addr != '0);
            wb_addr_q <= wr_addr;
         end else begin
            wb_pend   <= 1'b0;
         end
         // wb_addr_q is never 0 while wb_pend is set, so entry 0 stays zero.
         if (wb_pend)
            regs[wb_addr_q] <= wr_data;
         if (phase[PH_D]) begin
            rs_out <= rs_sel_c;
            rt_out <= rt_sel_c;
         end
      end
   end

   assign wb_busy = wb_pend;

endmodule
